fir_mac_seq: RTL

//  Sequencer and multiply-accumulate stage of the 6-tap FIR, directly downstream of the tap-select mux.

---
 rtl/fir_mac_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/fir_mac_seq.sv
// ---------------------------------------------------------------------------
// fir_mac_seq
//
// Sequencer and multiply-accumulate stage of a 6-tap FIR filter. It sits
// directly downstream of the tap-select mux. For each accepted sample it
// walks the mux selector I through 1..6 and multiplies the tap X returned
// for each selector value by the matching coefficient. After the sixth
// product it emits one saturated output sample and a one-cycle strobe that
// shifts the external delay line.
//
// Timing of one sample (E0 = edge that samples sample_valid):
//   I = k during (E(k-1), Ek) for k = 1..6
//   y_valid / shift_en high during (E6, E7), back in IDLE after E7
//
// Ports
//   clk          in   1        rising-edge clock
//   rst_n        in   1        synchronous reset, active low
//   sample_valid in   1        new sample present on DATTA (1-cycle strobe)
//   X            in   bits_X   selected tap from the mux (signed)
//   I            out  bits_I   registered mux selector, 0 = idle
//   shift_en     out  1        delay-line shift strobe
//   Y            out  bits_X   filtered output (signed), held between results
//   y_valid      out  1        one-cycle pulse when Y is updated
//   busy         out  1        high whenever the sequencer is not idle
//   overrun      out  1        sticky, sample_valid seen while busy
// ---------------------------------------------------------------------------
module fir_mac_seq #(
    parameter int bits_I   = 3,
    parameter int bits_X   = 16,
    parameter int bits_ACC = 35,
    parameter int FRAC     = 15,
    parameter logic signed [bits_X-1:0] C0 = bits_X'(5461),
    parameter logic signed [bits_X-1:0] C1 = bits_X'(5461),
    parameter logic signed [bits_X-1:0] C2 = bits_X'(5461),
    parameter logic signed [bits_X-1:0] C3 = bits_X'(5461),
    parameter logic signed [bits_X-1:0] C4 = bits_X'(5461),
    parameter logic signed [bits_X-1:0] C5 = bits_X'(5461)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [bits_X-1:0] X,
    output logic [bits_I-1:0] I,
    output logic              shift_en,
    output logic [bits_X-1:0] Y,
    output logic              y_valid,
    output logic              busy,
    output logic              overrun
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int PW = 2 * bits_X;

    localparam logic signed [bits_ACC-1:0] YMAX = bits_ACC'((2 ** (bits_X - 1)) - 1);
    localparam logic signed [bits_ACC-1:0] YMIN = -YMAX - bits_ACC'(1);

    logic [1:0]                 state_q, state_d;
    logic [bits_I-1:0]          i_q, i_d;
    logic signed [bits_ACC-1:0] acc_q, acc_d;
    logic [bits_X-1:0]          y_q, y_d;
    logic                       yv_q, yv_d;
    logic                       sh_q, sh_d;
    logic                       ovr_q, ovr_d;

    logic signed [bits_X-1:0]   coef;
    logic signed [PW-1:0]       prod;
    logic signed [bits_ACC-1:0] sum;
    logic signed [bits_ACC-1:0] shifted;
    logic [bits_X-1:0]          ySat;

    // The mux returns the oldest tap first (I=1 -> REG5), so the coefficient
    // order is reversed relative to the selector: I=1 pairs with C5 and I=6
    // pairs with C0, which weights the newest sample on DATTA.
    always_comb begin
        coef = '0;
        case (i_q)
            bits_I'(1): coef = C5;
            bits_I'(2): coef = C4;
            bits_I'(3): coef = C3;
            bits_I'(4): coef = C2;
            bits_I'(5): coef = C1;
            bits_I'(6): coef = C0;
            default:    coef = '0;
        endcase
    end

    // Full-precision signed product, sign-extended into the accumulator.
    // The accumulator is wide enough that six full-scale products cannot
    // overflow, so the only clipping happens once at the output. The
    // arithmetic right shift rounds toward minus infinity.
    always_comb begin
        prod    = PW'($signed(X)) * PW'(coef);
        sum     = acc_q + bits_ACC'(prod);
        shifted = sum >>> FRAC;
        if (shifted > YMAX) begin
            ySat = YMAX[bits_X-1:0];
        end else if (shifted < YMIN) begin
            ySat = YMIN[bits_X-1:0];
        end else begin
            ySat = shifted[bits_X-1:0];
        end
    end

    // Next-state logic for the sequencer. The strobes default low so that
    // y_valid and shift_en are single-cycle pulses on DONE entry. A sample
    // arriving outside IDLE never disturbs the running sequence; it only
    // latches the sticky overrun flag.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        acc_d   = acc_q;
        y_d     = y_q;
        yv_d    = 1'b0;
        sh_d    = 1'b0;
        ovr_d   = ovr_q;

        case (state_q)
            ST_IDLE: begin
                if (sample_valid) begin
                    acc_d   = '0;
                    i_d     = bits_I'(1);
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = sum;
                if (i_q == bits_I'(6)) begin
                    i_d     = '0;
                    state_d = ST_DONE;
                    y_d     = ySat;
                    yv_d    = 1'b1;
                    sh_d    = 1'b1;
                end else begin
                    i_d = i_q + bits_I'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                i_d     = '0;
            end
        endcase

        if (state_q != ST_IDLE && sample_valid) begin
            ovr_d = 1'b1;
        end
    end

    // State registers. Reset abandons any sample in flight: the strobes are
    // cleared along with the state, so no result or shift is produced for it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
            sh_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
            sh_q    <= sh_d;
            ovr_q   <= ovr_d;
        end
    end

    assign I        = i_q;
    assign Y        = y_q;
    assign y_valid  = yv_q;
    assign shift_en = sh_q;
    assign overrun  = ovr_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
